// File: rtl/fpmul_pipe_if.sv
// Operand/result handshake bundle for the FP32 pipelined multiplier.
// The master drives operands and consumes results; the slave is the multiplier.
interface fpmul_pipe_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out;
  logic        out_valid;
  logic        out_ready;
  logic        ovf;
  logic        unf;
  logic        nan;

  modport master (
    output a, b, in_valid, out_ready,
    input  in_ready, out, out_valid, ovf, unf, nan
  );

  modport slave (
    input  a, b, in_valid, out_ready,
    output in_ready, out, out_valid, ovf, unf, nan
  );
endinterface

// File: rtl/fpmul_pipe.sv
// 3-stage IEEE-754 single-precision multiplier (unpack / multiply / normalize-round-pack).
// Denormals flush to zero; every stage advances together under a single valid/ready advance.
module fpmul_pipe #(
  parameter int ROUND_MODE = 0
) (
  input logic         clk,
  input logic         rst,
  fpmul_pipe_if.slave bus
);

  localparam logic rne_c = (ROUND_MODE == 32'sd1);

  // Returns {nan, inf, zero} for one FP32 operand (exp==0 counts as zero).
  function automatic logic [2:0] classify(input logic [31:0] x);
    logic exp_max;
    logic exp_min;
    logic frac_nz;
    exp_max = (x[30:23] == 8'hFF);
    exp_min = (x[30:23] == 8'h00);
    frac_nz = (x[22:0] != 23'd0);
    return {exp_max & frac_nz, exp_max & ~frac_nz, exp_min};
  endfunction

  logic               adv_s;
  logic [2:0]         cls_a_s;
  logic [2:0]         cls_b_s;
  logic               nan_in_s;
  logic               inf_in_s;
  logic               zero_in_s;
  logic signed [9:0]  exp_sum_s;

  logic               v1_r;
  logic               sign1_r;
  logic signed [9:0]  exp1_r;
  logic [23:0]        ma1_r;
  logic [23:0]        mb1_r;
  logic               nan1_r;
  logic               inf1_r;
  logic               zero1_r;

  logic               v2_r;
  logic               sign2_r;
  logic signed [9:0]  exp2_r;
  logic [47:0]        p2_r;
  logic               nan2_r;
  logic               inf2_r;
  logic               zero2_r;

  logic [22:0]        mant_s;
  logic               guard_s;
  logic               sticky_s;
  logic               rnd_s;
  logic [23:0]        mant_rnd_s;
  logic signed [9:0]  exp_n_s;
  logic signed [9:0]  exp_f_s;
  logic [22:0]        mant_f_s;
  logic [31:0]        res_s;
  logic               ovf_s;
  logic               unf_s;
  logic               nan_s;

  logic               v3_r;
  logic [31:0]        out_r;
  logic               ovf_r;
  logic               unf_r;
  logic               nan_r;

  assign adv_s         = ~v3_r | bus.out_ready;
  assign bus.in_ready  = adv_s;
  assign bus.out       = out_r;
  assign bus.out_valid = v3_r;
  assign bus.ovf       = ovf_r;
  assign bus.unf       = unf_r;
  assign bus.nan       = nan_r;

  // Stage 1 combinational unpack: operand classes and biased exponent sum.
  always_comb begin
    cls_a_s   = classify(bus.a);
    cls_b_s   = classify(bus.b);
    // inf x zero is invalid and folds into the NaN class
    nan_in_s  = cls_a_s[2] | cls_b_s[2] | (cls_a_s[1] & cls_b_s[0]) | (cls_b_s[1] & cls_a_s[0]);
    inf_in_s  = cls_a_s[1] | cls_b_s[1];
    zero_in_s = cls_a_s[0] | cls_b_s[0];
    exp_sum_s = $signed({2'b00, bus.a[30:23]} + {2'b00, bus.b[30:23]} - 10'd127);
  end

  // Stage 1 register: sign, exponent sum, mantissas with hidden bit, class bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r    <= 1'b0;
      sign1_r <= 1'b0;
      exp1_r  <= 10'sd0;
      ma1_r   <= 24'd0;
      mb1_r   <= 24'd0;
      nan1_r  <= 1'b0;
      inf1_r  <= 1'b0;
      zero1_r <= 1'b0;
    end else if (adv_s) begin
      v1_r    <= bus.in_valid;
      sign1_r <= bus.a[31] ^ bus.b[31];
      exp1_r  <= exp_sum_s;
      ma1_r   <= {1'b1, bus.a[22:0]};
      mb1_r   <= {1'b1, bus.b[22:0]};
      nan1_r  <= nan_in_s;
      inf1_r  <= inf_in_s;
      zero1_r <= zero_in_s;
    end
  end

  // Stage 2 register: full 48-bit mantissa product plus forwarded fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_r    <= 1'b0;
      sign2_r <= 1'b0;
      exp2_r  <= 10'sd0;
      p2_r    <= 48'd0;
      nan2_r  <= 1'b0;
      inf2_r  <= 1'b0;
      zero2_r <= 1'b0;
    end else if (adv_s) begin
      v2_r    <= v1_r;
      sign2_r <= sign1_r;
      exp2_r  <= exp1_r;
      p2_r    <= {24'd0, ma1_r} * {24'd0, mb1_r};
      nan2_r  <= nan1_r;
      inf2_r  <= inf1_r;
      zero2_r <= zero1_r;
    end
  end

  // Stage 3 combinational normalize, round and special-case selection.
  always_comb begin
    if (p2_r[47]) begin
      mant_s   = p2_r[46:24];
      guard_s  = p2_r[23];
      sticky_s = |p2_r[22:0];
      exp_n_s  = exp2_r + 10'sd1;
    end else begin
      mant_s   = p2_r[45:23];
      guard_s  = p2_r[22];
      sticky_s = |p2_r[21:0];
      exp_n_s  = exp2_r;
    end

    rnd_s      = rne_c & guard_s & (sticky_s | mant_s[0]);
    mant_rnd_s = {1'b0, mant_s} + {23'd0, rnd_s};

    // a carry out of the rounded mantissa means the significand became 2.0
    if (mant_rnd_s[23]) begin
      exp_f_s  = exp_n_s + 10'sd1;
      mant_f_s = 23'd0;
    end else begin
      exp_f_s  = exp_n_s;
      mant_f_s = mant_rnd_s[22:0];
    end

    res_s = 32'd0;
    ovf_s = 1'b0;
    unf_s = 1'b0;
    nan_s = 1'b0;
    if (nan2_r) begin
      res_s = 32'h7FC0_0000;
      nan_s = 1'b1;
    end else if (inf2_r) begin
      res_s = {sign2_r, 8'hFF, 23'd0};
    end else if (zero2_r) begin
      res_s = {sign2_r, 31'd0};
    end else if (exp_f_s >= 10'sd255) begin
      res_s = {sign2_r, 8'hFF, 23'd0};
      ovf_s = 1'b1;
    end else if (exp_f_s <= 10'sd0) begin
      res_s = {sign2_r, 31'd0};
      unf_s = 1'b1;
    end else begin
      res_s = {sign2_r, exp_f_s[7:0], mant_f_s};
    end
  end

  // Stage 3 register: packed result and flags; bubbles leave zeros behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_r  <= 1'b0;
      out_r <= 32'd0;
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
      nan_r <= 1'b0;
    end else if (adv_s) begin
      v3_r  <= v2_r;
      out_r <= v2_r ? res_s : 32'd0;
      ovf_r <= v2_r & ovf_s;
      unf_r <= v2_r & unf_s;
      nan_r <= v2_r & nan_s;
    end
  end

endmodule

// File: tb/tb_fpmul_pipe.sv
// Bench for fpmul_pipe: one round-to-nearest-even and one truncating instance share stimulus,
// each checked against an arithmetic FP32 product model through its own expectation queue.
module tb_fpmul_pipe;
  logic clk = 1'b0;
  logic rst;

  fpmul_pipe_if bus1 ();
  fpmul_pipe_if bus0 ();

  assign bus0.a         = bus1.a;
  assign bus0.b         = bus1.b;
  assign bus0.in_valid  = bus1.in_valid;
  assign bus0.out_ready = bus1.out_ready;

  fpmul_pipe #(.ROUND_MODE(1)) dut_rne (.clk(clk), .rst(rst), .bus(bus1));
  fpmul_pipe #(.ROUND_MODE(0)) dut_trn (.clk(clk), .rst(rst), .bus(bus0));

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [34:0] e1q[$];
  logic [34:0] e0q[$];
  logic        use_tbl = 1'b0;
  logic [34:0] tbl1 = 35'd0;
  logic [34:0] tbl0 = 35'd0;
  logic        hold1 = 1'b0;
  logic        hold0 = 1'b0;
  logic [35:0] held1 = 36'd0;
  logic [35:0] held0 = 36'd0;
  logic        last_acc = 1'b0;
  logic        last_ir = 1'b0;
  logic        last_ov = 1'b0;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference product {nan, unf, ovf, out}: exact integer product, remainder-vs-half rounding.
  function automatic logic [34:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input int rm);
    int ex, ey, e, sh;
    logic s, xz, xi, xn, yz, yi, yn;
    longint unsigned p, m, rem, half;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 23'd0);
    yi = (ey == 255) && (y[22:0] == 23'd0);
    xn = (ex == 255) && (x[22:0] != 23'd0);
    yn = (ey == 255) && (y[22:0] != 23'd0);
    if (xn || yn || (xi && yz) || (yi && xz)) return {3'b100, 32'h7FC0_0000};
    if (xi || yi) return {3'b000, s, 8'hFF, 23'd0};
    if (xz || yz) return {3'b000, s, 31'd0};
    p    = {40'd0, 1'b1, x[22:0]} * {40'd0, 1'b1, y[22:0]};
    e    = ex + ey - 127;
    sh   = (p >= (64'd1 << 47)) ? 24 : 23;
    e    = e + sh - 23;
    m    = p >> sh;
    rem  = p - (m << sh);
    half = 64'd1 << (sh - 1);
    if (rm == 1 && (rem > half || (rem == half && m[0]))) m = m + 64'd1;
    if (m == (64'd1 << 24)) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {3'b001, s, 8'hFF, 23'd0};
    if (e <= 0) return {3'b010, s, 31'd0};
    return {3'b000, s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [7:0]  ex;
    logic [22:0] fr;
    logic        sg;
    sg = 1'($urandom_range(0, 1));
    fr = 23'($urandom());
    case ($urandom_range(0, 9))
      0: ex = 8'h00;
      1: begin ex = 8'hFF; fr = 23'd0; end
      2: begin ex = 8'hFF; fr = fr | 23'd1; end
      3: ex = 8'($urandom_range(200, 254));
      4: ex = 8'($urandom_range(1, 50));
      default: ex = 8'($urandom_range(100, 154));
    endcase
    return {sg, ex, fr};
  endfunction

  // One clock: sample just before the edge, score handshakes, then cross the edge.
  task automatic step();
    logic acc1, acc0, con1, con0;
    logic [35:0] cur1, cur0;
    #1;
    cur1 = {bus1.out_valid, bus1.nan, bus1.unf, bus1.ovf, bus1.out};
    cur0 = {bus0.out_valid, bus0.nan, bus0.unf, bus0.ovf, bus0.out};
    acc1 = bus1.in_valid & bus1.in_ready;
    acc0 = bus0.in_valid & bus0.in_ready;
    con1 = bus1.out_valid & bus1.out_ready;
    con0 = bus0.out_valid & bus0.out_ready;
    last_acc = acc1;
    last_ir  = bus1.in_ready;
    last_ov  = bus1.out_valid;
    if (hold1) chk("hold_rne", cur1, held1);
    if (hold0) chk("hold_trn", cur0, held0);
    if (con1) begin
      if (e1q.size() == 0) chk("spurious_rne", cur1, 36'd0);
      else chk("out_rne", cur1, {1'b1, e1q.pop_front()});
    end
    if (con0) begin
      if (e0q.size() == 0) chk("spurious_trn", cur0, 36'd0);
      else chk("out_trn", cur0, {1'b1, e0q.pop_front()});
    end
    if (acc1) e1q.push_back(use_tbl ? tbl1 : ref_mul(bus1.a, bus1.b, 1));
    if (acc0) e0q.push_back(use_tbl ? tbl0 : ref_mul(bus0.a, bus0.b, 0));
    hold1 = bus1.out_valid & ~bus1.out_ready;
    hold0 = bus0.out_valid & ~bus0.out_ready;
    held1 = cur1;
    held0 = cur0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [34:0] r1;
    logic [34:0] r0;
  } vec_t;

  vec_t dir[9];
  int   k;
  int   lat;

  initial begin
    dir[0] = '{32'h4000_0000, 32'h4040_0000, {3'b000, 32'h40C0_0000}, {3'b000, 32'h40C0_0000}};
    dir[1] = '{32'h3FC0_0000, 32'hBFC0_0000, {3'b000, 32'hC010_0000}, {3'b000, 32'hC010_0000}};
    dir[2] = '{32'hBF80_0000, 32'h0000_0000, {3'b000, 32'h8000_0000}, {3'b000, 32'h8000_0000}};
    dir[3] = '{32'h3F80_0001, 32'h3FC0_0000, {3'b000, 32'h3FC0_0002}, {3'b000, 32'h3FC0_0001}};
    dir[4] = '{32'h7F80_0000, 32'h0000_0000, {3'b100, 32'h7FC0_0000}, {3'b100, 32'h7FC0_0000}};
    dir[5] = '{32'h7F00_0000, 32'h7F00_0000, {3'b001, 32'h7F80_0000}, {3'b001, 32'h7F80_0000}};
    dir[6] = '{32'h0080_0000, 32'h3F00_0000, {3'b010, 32'h0000_0000}, {3'b010, 32'h0000_0000}};
    dir[7] = '{32'h7FC0_0001, 32'h3F80_0000, {3'b100, 32'h7FC0_0000}, {3'b100, 32'h7FC0_0000}};
    dir[8] = '{32'h3FFF_FFFE, 32'h3F80_0001, {3'b000, 32'h4000_0000}, {3'b000, 32'h3FFF_FFFF}};

    rst = 1'b1;
    bus1.a = 32'd0;
    bus1.b = 32'd0;
    bus1.in_valid = 1'b0;
    bus1.out_ready = 1'b0;
    #2;
    chk("reset_out_rne", {bus1.out_valid, bus1.nan, bus1.unf, bus1.ovf, bus1.out}, 36'd0);
    chk("reset_out_trn", {bus0.out_valid, bus0.nan, bus0.unf, bus0.ovf, bus0.out}, 36'd0);
    chk("reset_in_ready", {35'd0, bus1.in_ready}, 36'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed vectors, back to back, with a free-running consumer.
    use_tbl = 1'b1;
    bus1.out_ready = 1'b1;
    foreach (dir[i]) begin
      bus1.a = dir[i].a;
      bus1.b = dir[i].b;
      tbl1 = dir[i].r1;
      tbl0 = dir[i].r0;
      bus1.in_valid = 1'b1;
      step();
    end
    use_tbl = 1'b0;
    bus1.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("directed_drain", {4'd0, 32'(e1q.size() + e0q.size())}, 36'd0);

    // Backpressure: five products offered while the consumer is stalled.
    k = 0;
    bus1.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus1.in_valid = (k < 5);
      bus1.a = rnd_op();
      bus1.b = rnd_op();
      step();
      if (last_acc) k++;
    end
    chk("bp_accepts", {4'd0, 32'(k)}, 36'd3);
    chk("bp_in_ready", {35'd0, last_ir}, 36'd0);
    bus1.out_ready = 1'b1;
    for (int i = 0; i < 20 && (k < 5 || e1q.size() != 0); i++) begin
      bus1.in_valid = (k < 5);
      bus1.a = rnd_op();
      bus1.b = rnd_op();
      step();
      if (last_acc) k++;
    end
    bus1.in_valid = 1'b0;
    step();
    chk("bp_total", {4'd0, 32'(k)}, 36'd5);
    chk("bp_drain", {4'd0, 32'(e1q.size() + e0q.size())}, 36'd0);

    // Random traffic with random stalls and bubbles.
    for (int i = 0; i < 400; i++) begin
      bus1.a = rnd_op();
      bus1.b = rnd_op();
      bus1.in_valid = ($urandom_range(0, 9) < 7);
      bus1.out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    bus1.in_valid = 1'b0;
    bus1.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("random_drain", {4'd0, 32'(e1q.size() + e0q.size())}, 36'd0);

    // Asynchronous reset with three operations in flight.
    bus1.out_ready = 1'b0;
    bus1.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus1.a = 32'h4000_0000 + 32'(i << 20);
      bus1.b = 32'h3FC0_0000;
      step();
    end
    rst = 1'b1;
    #1;
    chk("async_rst_rne", {bus1.out_valid, bus1.nan, bus1.unf, bus1.ovf, bus1.out}, 36'd0);
    chk("async_rst_trn", {bus0.out_valid, bus0.nan, bus0.unf, bus0.ovf, bus0.out}, 36'd0);
    e1q.delete();
    e0q.delete();
    hold1 = 1'b0;
    hold0 = 1'b0;
    bus1.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus1.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no_stale", {35'd0, last_ov}, 36'd0);
    end

    // Fresh operation after reset: exactly three cycles to out_valid.
    bus1.a = 32'h4000_0000;
    bus1.b = 32'h4040_0000;
    bus1.in_valid = 1'b1;
    step();
    bus1.in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      step();
      if (last_ov) lat = i;
    end
    chk("latency", {4'd0, 32'(lat)}, 36'd3);
    for (int i = 0; i < 3; i++) step();
    chk("final_drain", {4'd0, 32'(e1q.size() + e0q.size())}, 36'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fpmul_pipe.md
Name: fpmul_pipe

Overview:
- 3-stage pipelined IEEE-754 single-precision multiplier; the upstream stage of the floating-point MAC.
- Its product feeds the `a` operand of the FP adder, and the adder's output is fed back as the accumulator.
- Valid/ready handshake on both sides so the MAC controller can stall it while the adder pipeline drains.

Parameters:
- ROUND_MODE, 0, 0 = truncate (round toward zero), 1 = round-to-nearest-even.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- a  in  32  operand A, FP32 {sign, exp[7:0], frac[22:0]}
- b  in  32  operand B, FP32
- in_valid  in  1  a/b valid this cycle
- in_ready  out  1  block accepts a/b this cycle
- out  out  32  FP32 product
- out_valid  out  1  out holds a valid product
- out_ready  in  1  downstream consumes out this cycle
- ovf  out  1  product overflowed to infinity (qualified by out_valid)
- unf  out  1  product underflowed/flushed to zero (qualified by out_valid)
- nan  out  1  product is NaN (qualified by out_valid)

Behaviour:
- Reset (async, rst=1): all stage valid bits 0; out=0, out_valid=0, ovf=unf=nan=0. Data registers cleared. Any in-flight operations are discarded; the first valid output after reset release needs a fresh accept.
- Handshake:
  - Global advance: adv = ~out_valid | out_ready.
  - in_ready = adv (combinational).
  - Accept on in_valid & in_ready.
  - When adv=0 all stages hold, and out/flags stay stable.
  - A bubble (in_valid=0 while adv=1) propagates as valid=0.
- Latency: 3 cycles from accept to out_valid with no stall. Throughput: 1 per cycle.
- Stage 1 (unpack/classify):
  - sign = a[31]^b[31].
  - exp_sum = ea+eb-127, computed in 10-bit signed arithmetic.
  - Mantissas get the hidden bit: {1,frac}.
  - Classes: zero (exp=0; denormals are flushed to zero), inf (exp=255, frac=0), nan (exp=255, frac≠0).
- Stage 2: 24x24 unsigned mantissa product, 48 bits, registered together with sign, exp_sum and class bits.
- Stage 3 (normalize/round/pack):
  - If p[47]=1: mant = p[46:24], guard = p[23], sticky = |p[22:0], exp+1.
  - Else: mant = p[45:23], guard = p[22], sticky = |p[21:0].
  - ROUND_MODE=1: increment mant when guard & (sticky | mant[0]). A carry out of the mantissa increments exp and zeroes mant.
  - ROUND_MODE=0: no increment.
- Result selection, in priority order:
  1. Any NaN operand, or inf×zero: out = 32'h7FC00000, nan=1.
  2. Inf operand (other one nonzero): out = {sign, 8'hFF, 23'h0}.
  3. Zero operand: out = {sign, 31'h0}; unf=0.
  4. Final exp >= 255: out = {sign, 8'hFF, 0}, ovf=1.
  5. Final exp <= 0: out = {sign, 31'h0}, unf=1.
  6. Otherwise: {sign, exp[7:0], mant}.
- Flags are registered alongside out. At most one of ovf/unf/nan is 1.
- Simultaneous accept and output consume in the same cycle is legal. The pipeline shifts by one, with no loss or duplication.

Test Plan:
- 2.0×3.0: a=40000000, b=40400000, in_valid for one cycle -> after 3 cycles out=40C00000, out_valid=1 for one cycle (out_ready=1), flags 0.
- Normalize shift and sign: 1.5×(-1.5) (3FC00000, BFC00000) -> C0100000. -1.0×0.0 (BF800000, 00000000) -> 80000000, unf=0.
- Rounding: 3F800001×3FC00000 -> ROUND_MODE=0 gives 3FC00001; ROUND_MODE=1 gives 3FC00002 (tie, odd LSB).
- Specials:
  - 7F800000×00000000 -> 7FC00000, nan=1.
  - 7F000000×7F000000 -> 7F800000, ovf=1.
  - 00800000×3F000000 -> 00000000, unf=1.
  - 7FC00001×3F800000 -> 7FC00000, nan=1.
- Backpressure: stream 5 back-to-back products with out_ready=0 -> in_ready drops after 3 accepts (stages full), out holds the first product stably. Raise out_ready -> 5 results emerge in order, none lost or duplicated.
- Async reset mid-stream: assert rst while 3 ops are in flight -> out_valid=0 and out=0 immediately, without waiting for a clock edge. After release, no stale results appear; a new op emerges exactly 3 cycles after its accept.
